// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, diff = a - b - bin
//
// Computes one result bit per clock, LSB first, through a single full-subtractor
// cell. A start pulse in IDLE or DONE latches the operands. WIDTH bit edges
// later the FSM enters DONE for one cycle with diff/bout valid. The result is
// held until the next operation begins shifting.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, honoured only in IDLE or DONE
//   a      in   minuend, sampled with start
//   b      in   subtrahend, sampled with start
//   bin    in   borrow-in, sampled with start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, diff/bout valid
//   diff   out  result (intermediate while busy)
//   bout   out  borrow-out, 1 when a < b + bin (unsigned)
//   ovf    out  signed overflow, present only with SERIAL_SUBTRACTOR_OVF_EN
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q;
`endif

    // Full-subtractor cell on the current LSBs and the running borrow.
    logic bit_d;
    logic br_d;

    always_comb begin
        bit_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                // DONE accepts a new start exactly like IDLE so that
                // back-to-back operations need no gap cycle.
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    diff_q <= {bit_d, diff_q[WIDTH-1:1]};
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        bout_q  <= br_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        // Borrow into the MSB differs from borrow out of it.
                        ovf_q   <= br_q ^ br_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the definition of a - b - bin.
    function automatic logic [W-1:0] ref_diff(input int ua, input int ub, input int ubin);
        int r;
        r = ua - ub - ubin;
        return W'(r & ((1 << W) - 1));
    endfunction

    function automatic logic ref_bout(input int ua, input int ub, input int ubin);
        return ua < (ub + ubin);
    endfunction

    function automatic logic ref_ovf(input int ua, input int ub, input int ubin);
        int sa, sb, r;
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        r  = sa - sb - ubin;
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    // Timeline model: an operation accepted at edge e is busy after edges
    // e..e+W-1, and its result appears with done after edge e+W.
    int           cyc     = 0;
    int           op_edge = -1000;
    logic [W-1:0] p_diff, m_diff = '0;
    logic         p_bout, m_bout = 1'b0;
    logic         p_ovf,  m_ovf  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_edge = -1000;
            m_diff  = '0;
            m_bout  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            cyc++;
            if (start && cyc > op_edge + W) begin
                op_edge = cyc;
                p_diff  = ref_diff(int'(a), int'(b), int'(bin));
                p_bout  = ref_bout(int'(a), int'(b), int'(bin));
                p_ovf   = ref_ovf(int'(a), int'(b), int'(bin));
            end
            if (cyc == op_edge + W) begin
                m_diff = p_diff;
                m_bout = p_bout;
                m_ovf  = p_ovf;
            end
        end
    end

    // Per-cycle compare against the timeline model.
    always @(negedge clk) begin
        logic exp_busy, exp_done;
        exp_busy = rst_n && (cyc >= op_edge) && (cyc < op_edge + W);
        exp_done = rst_n && (cyc == op_edge + W);
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        check("bout", 32'(bout), 32'(m_bout));
        if (!exp_busy) check("diff", 32'(diff), 32'(m_diff));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end

    // Count posedges from the start edge until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 3 * W) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                      input logic [W-1:0] ed, input logic eb, input string name);
        int lat;
        @(negedge clk); #1;
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        check({name, "_lat"},  32'(lat),  32'(W));
        check({name, "_diff"}, 32'(diff), 32'(ed));
        check({name, "_bout"}, 32'(bout), 32'(eb));
    endtask

    initial begin
        int lat;
        int pulses;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        op(4'b0100, 4'b0001, 1'b0, 4'b0011, 1'b0, "op_4m1");
        op(4'b0101, 4'b0111, 1'b0, 4'b1110, 1'b1, "op_5m7");
        op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, "op_0m0b");
        @(negedge clk); #1;
        check("held_diff", 32'(diff), 32'b1111);

        // Back-to-back: start held high, second operand set loaded from DONE.
        @(negedge clk); #1;
        a = 4'b1000; b = 4'b0011; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wait_done(lat);
        check("b2b1_lat",  32'(lat),  32'(W));
        check("b2b1_diff", 32'(diff), 32'b0101);
        check("b2b1_bout", 32'(bout), 32'd0);
        a = 4'b1111; b = 4'b1110;
        @(posedge clk); #1;
        check("b2b_nogap_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(lat);
        check("b2b2_lat",  32'(lat),  32'(W));
        check("b2b2_diff", 32'(diff), 32'b0001);
        check("b2b2_bout", 32'(bout), 32'd0);

        // Start while busy is ignored.
        @(negedge clk); #1;
        a = 4'b0100; b = 4'b0001; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 4'b1111; b = 4'b0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                check("ign_diff", 32'(diff), 32'b0011);
                check("ign_bout", 32'(bout), 32'd0);
            end
        end
        check("ign_pulses", 32'(pulses), 32'd1);

        // Reset at bit 2 aborts the operation.
        @(negedge clk); #1;
        a = 4'b0111; b = 4'b0010; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        pulses = 0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        op(4'b1001, 4'b0011, 1'b1, 4'b0101, 1'b0, "post_rst");

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        op(4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, "ovf_op1");
        check("ovf_set", 32'(ovf), 32'd1);
        op(4'b0100, 4'b0001, 1'b0, 4'b0011, 1'b0, "ovf_op2");
        check("ovf_clr", 32'(ovf), 32'd0);
`endif

        // Random traffic: start toggles freely, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
            start = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

endmodule
